// File: rtl/frame_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_write_scheduler_if
// Brief    : Frame/source/swap handshake bundle around frame_write_scheduler.
// Revision : 1.0
// ============================================================================
interface frame_write_scheduler_if #(
    parameter int NUM_SOURCES = 2,
    parameter int SEL_WIDTH   = 1
);
    logic                   frame;
    logic [NUM_SOURCES-1:0] src_enable;
    logic [NUM_SOURCES-1:0] src_done;
    logic                   swap_ack;
    logic [SEL_WIDTH-1:0]   write_source_sel;
    logic                   write_awaited;
    logic [NUM_SOURCES-1:0] src_grant;
    logic                   swap_req;
    logic                   busy;
    logic                   timeout_flag;
    logic [7:0]             missed_frames;

    // Scheduler side: owns the write-port grant and the swap request.
    modport master (
        input  frame, src_enable, src_done, swap_ack,
        output write_source_sel, write_awaited, src_grant,
               swap_req, busy, timeout_flag, missed_frames
    );

    // Environment side: screen controller, drawing units, frame manager.
    modport slave (
        output frame, src_enable, src_done, swap_ack,
        input  write_source_sel, write_awaited, src_grant,
               swap_req, busy, timeout_flag, missed_frames
    );
endinterface
`default_nettype wire

// File: rtl/frame_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_write_scheduler
// Brief    : Painter's-order arbiter for the frame buffer write port.
// Revision : 1.0
// ============================================================================
module frame_write_scheduler #(
    parameter int NUM_SOURCES    = 2,
    parameter int SEL_WIDTH      = 1,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  wire logic               clk,
    input  wire logic               reset,
    frame_write_scheduler_if.master bus
);
    localparam logic [TIMEOUT_WIDTH-1:0] c_TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_WIDTH-1:0]     c_LAST_SRC     = SEL_WIDTH'(NUM_SOURCES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_GRANT = 3'd2,
        S_GAP   = 3'd3,
        S_SWAP  = 3'd4
    } state_t;

    state_t                   state_q;
    logic [SEL_WIDTH-1:0]     sel_q;
    logic                     awaited_q;
    logic [NUM_SOURCES-1:0]   grant_q;
    logic                     swap_req_q;
    logic                     busy_q;
    logic                     timeout_q;
    logic [7:0]               missed_q;
    logic                     pending_q;
    logic [TIMEOUT_WIDTH-1:0] timer_q;

    logic                     scan_hit_d;
    logic [SEL_WIDTH-1:0]     scan_idx_d;
    logic                     done_sel;

    // Descending walk so the lowest enabled index >= sel_q wins.
    always_comb begin
        scan_hit_d = 1'b0;
        scan_idx_d = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (i >= int'(sel_q) && bus.src_enable[i]) begin
                scan_hit_d = 1'b1;
                scan_idx_d = SEL_WIDTH'(i);
            end
        end
    end

    assign done_sel = bus.src_done[sel_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            awaited_q  <= 1'b0;
            grant_q    <= '0;
            swap_req_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            missed_q   <= 8'd0;
            pending_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            if (bus.frame && busy_q) begin
                pending_q <= 1'b1;
                if (missed_q != 8'hFF) begin
                    missed_q <= missed_q + 8'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.frame || pending_q) begin
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                        sel_q     <= '0;
                        state_q   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_hit_d) begin
                        sel_q     <= scan_idx_d;
                        timer_q   <= '0;
                        awaited_q <= 1'b1;
                        grant_q   <= NUM_SOURCES'(1) << scan_idx_d;
                        state_q   <= S_GRANT;
                    end else begin
                        swap_req_q <= 1'b1;
                        state_q    <= S_SWAP;
                    end
                end
                S_GRANT: begin
                    if (done_sel || timer_q == c_TIMEOUT_LAST) begin
                        awaited_q <= 1'b0;
                        grant_q   <= '0;
                        state_q   <= S_GAP;
                        if (!done_sel) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMEOUT_WIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (sel_q == c_LAST_SRC) begin
                        state_q <= S_SWAP;
                    end else begin
                        sel_q   <= sel_q + SEL_WIDTH'(1);
                        state_q <= S_SCAN;
                    end
                end
                S_SWAP: begin
                    // Arriving from GAP, the request rises one cycle after entry.
                    if (!swap_req_q) begin
                        swap_req_q <= 1'b1;
                    end else if (bus.swap_ack) begin
                        swap_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.write_source_sel = sel_q;
    assign bus.write_awaited    = awaited_q;
    assign bus.src_grant        = grant_q;
    assign bus.swap_req         = swap_req_q;
    assign bus.busy             = busy_q;
    assign bus.timeout_flag     = timeout_q;
    assign bus.missed_frames    = missed_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_write_scheduler
// Brief    : Directed bench; u_a uses a long timeout, u_t a 16-cycle timeout.
// Revision : 1.0
// ============================================================================
module tb_frame_write_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] done = 2'b00;
    logic       ack = 1'b0;
    int         cyc = 0;
    int         n_run = 0;
    int         n_fail = 0;

    frame_write_scheduler_if #(.NUM_SOURCES(2), .SEL_WIDTH(1)) ifa ();
    frame_write_scheduler_if #(.NUM_SOURCES(2), .SEL_WIDTH(1)) ift ();

    assign ifa.frame = frame;  assign ift.frame = frame;
    assign ifa.src_enable = en; assign ift.src_enable = en;
    assign ifa.src_done = done; assign ift.src_done = done;
    assign ifa.swap_ack = ack;  assign ift.swap_ack = ack;

    frame_write_scheduler #(.NUM_SOURCES(2), .SEL_WIDTH(1), .TIMEOUT_CYCLES(1000), .TIMEOUT_WIDTH(20))
        u_a (.clk(clk), .reset(reset), .bus(ifa.master));
    frame_write_scheduler #(.NUM_SOURCES(2), .SEL_WIDTH(1), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(20))
        u_t (.clk(clk), .reset(reset), .bus(ift.master));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle: inputs set after step() are sampled at the next edge,
    // and outputs read after step() are the registered values for this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        frame = 1'b0;
        done  = 2'b00;
        ack   = 1'b0;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic restart(input logic [1:0] enable);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        en    = enable;
        cyc   = 0;
    endtask

    initial begin
        #1;
        // Reset values
        restart(2'b11);
        chk("rst_busy", 32'(ifa.busy), 0);
        chk("rst_awaited", 32'(ifa.write_awaited), 0);
        chk("rst_grant", 32'(ifa.src_grant), 0);
        chk("rst_swap", 32'(ifa.swap_req), 0);
        chk("rst_sel", 32'(ifa.write_source_sel), 0);
        chk("rst_missed", 32'(ifa.missed_frames), 0);

        // Basic two-source sequence
        frame = 1'b1;
        go_to(1);  chk("b_busy1", 32'(ifa.busy), 1);
                   chk("b_grant1", 32'(ifa.src_grant), 0);
        go_to(2);  chk("b_grant2", 32'(ifa.src_grant), 32'b01);
                   chk("b_awaited2", 32'(ifa.write_awaited), 1);
                   chk("b_sel2", 32'(ifa.write_source_sel), 0);
        go_to(10); done = 2'b01;
                   chk("b_grant10", 32'(ifa.src_grant), 32'b01);
        go_to(11); chk("b_grant11", 32'(ifa.src_grant), 0);
                   chk("b_awaited11", 32'(ifa.write_awaited), 0);
        go_to(12); chk("b_grant12", 32'(ifa.src_grant), 0);
        go_to(13); chk("b_grant13", 32'(ifa.src_grant), 32'b10);
                   chk("b_sel13", 32'(ifa.write_source_sel), 1);
        go_to(30); done = 2'b10;
                   chk("b_grant30", 32'(ifa.src_grant), 32'b10);
        go_to(31); chk("b_grant31", 32'(ifa.src_grant), 0);
        go_to(32); chk("b_swap32", 32'(ifa.swap_req), 0);
        go_to(33); chk("b_swap33", 32'(ifa.swap_req), 1);
        go_to(35); ack = 1'b1;
                   chk("b_swap35", 32'(ifa.swap_req), 1);
                   chk("b_busy35", 32'(ifa.busy), 1);
        go_to(36); chk("b_swap36", 32'(ifa.swap_req), 0);
                   chk("b_busy36", 32'(ifa.busy), 0);
                   chk("b_tmo", 32'(ifa.timeout_flag), 0);

        // Skip disabled source 0
        restart(2'b10);
        frame = 1'b1;
        go_to(1);  chk("s_grant1", 32'(ifa.src_grant), 0);
        go_to(2);  chk("s_grant2", 32'(ifa.src_grant), 32'b10);
                   chk("s_sel2", 32'(ifa.write_source_sel), 1);
        go_to(5);  done = 2'b10;
        go_to(7);  chk("s_swap7", 32'(ifa.swap_req), 0);
        go_to(8);  chk("s_swap8", 32'(ifa.swap_req), 1);
                   ack = 1'b1;
        go_to(9);  chk("s_busy9", 32'(ifa.busy), 0);

        // All sources disabled
        restart(2'b00);
        frame = 1'b1;
        go_to(2);  chk("z_swap2", 32'(ifa.swap_req), 1);
                   chk("z_grant2", 32'(ifa.src_grant), 0);
                   chk("z_awaited2", 32'(ifa.write_awaited), 0);
                   ack = 1'b1;
        go_to(3);  chk("z_busy3", 32'(ifa.busy), 0);

        // Timeout on the 16-cycle instance
        restart(2'b11);
        frame = 1'b1;
        go_to(2);  chk("t_grant2", 32'(ift.src_grant), 32'b01);
        go_to(17); chk("t_grant17", 32'(ift.src_grant), 32'b01);
                   chk("t_flag17", 32'(ift.timeout_flag), 0);
        go_to(18); chk("t_grant18", 32'(ift.src_grant), 0);
                   chk("t_flag18", 32'(ift.timeout_flag), 1);
        go_to(19); chk("t_grant19", 32'(ift.src_grant), 0);
        go_to(20); chk("t_grant20", 32'(ift.src_grant), 32'b10);
                   chk("t_sel20", 32'(ift.write_source_sel), 1);

        // Missed frames with pending service; only source 0 enabled
        restart(2'b01);
        frame = 1'b1;
        go_to(3);  frame = 1'b1;
        go_to(5);  frame = 1'b1;
        go_to(7);  frame = 1'b1;
        go_to(8);  done = 2'b01;
                   chk("m_missed8", 32'(ifa.missed_frames), 3);
        go_to(11); chk("m_swap11", 32'(ifa.swap_req), 1);
                   ack = 1'b1;
        go_to(12); chk("m_busy12", 32'(ifa.busy), 0);
                   chk("m_missed12", 32'(ifa.missed_frames), 3);
        go_to(13); chk("m_busy13", 32'(ifa.busy), 1);
        go_to(14); chk("m_grant14", 32'(ifa.src_grant), 32'b01);
                   done = 2'b01;
        go_to(17); chk("m_swap17", 32'(ifa.swap_req), 1);
                   ack = 1'b1;
        go_to(18); chk("m_busy18", 32'(ifa.busy), 0);
        go_to(20); chk("m_busy20", 32'(ifa.busy), 0);
                   chk("m_missed20", 32'(ifa.missed_frames), 3);
        // Frame coinciding with swap_ack counts as missed, then restarts
        go_to(21); frame = 1'b1;
        go_to(23); done = 2'b01;
        go_to(26); chk("c_swap26", 32'(ifa.swap_req), 1);
                   ack = 1'b1;
                   frame = 1'b1;
        go_to(27); chk("c_busy27", 32'(ifa.busy), 0);
                   chk("c_missed27", 32'(ifa.missed_frames), 4);
        go_to(28); chk("c_busy28", 32'(ifa.busy), 1);

        // Stray done/ack during grant 0, then reset mid-grant
        restart(2'b11);
        frame = 1'b1;
        go_to(4);  done = 2'b10;
                   ack = 1'b1;
        go_to(5);  chk("x_grant5", 32'(ifa.src_grant), 32'b01);
                   chk("x_swap5", 32'(ifa.swap_req), 0);
                   frame = 1'b1;
        go_to(6);  chk("x_grant6", 32'(ifa.src_grant), 32'b01);
                   chk("x_missed6", 32'(ifa.missed_frames), 1);
        go_to(20); chk("x_grant20", 32'(ifa.src_grant), 32'b01);
                   chk("x_tflag20", 32'(ift.timeout_flag), 1);
                   reset = 1'b1;
        go_to(21); chk("r_grant", 32'(ifa.src_grant), 0);
                   chk("r_awaited", 32'(ifa.write_awaited), 0);
                   chk("r_busy", 32'(ifa.busy), 0);
                   chk("r_swap", 32'(ifa.swap_req), 0);
                   chk("r_sel", 32'(ifa.write_source_sel), 0);
                   chk("r_missed", 32'(ifa.missed_frames), 0);
                   chk("r_tflag", 32'(ift.timeout_flag), 0);
                   chk("r_tgrant", 32'(ift.src_grant), 0);
        reset = 1'b0;
        go_to(23); chk("r_idle23", 32'(ifa.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
